mixed_precision_unpacker: RTL and testbench
===========================================

Name: mixed_precision_unpacker

Overview:
- Streaming decoder for per-token mixed-precision V data. It is the inverse of the attention path's INT4/INT8/FP16 downcast.
- Input is a packed word stream plus one precision code per token. Output is one element per handshake, each element zero-extended to DATA_WIDTH.
- Sits between the packed V buffer and the attention MULV datapath. Each run decodes L tokens of E elements.

Parameters:
DATA_WIDTH  16  output element width; must be 16
L  8  tokens per run
E  8  elements per token
IN_W  32  packed input word width; a multiple of 16

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begins a run; only sampled in IDLE
done  output  1  one-cycle pulse at end of run
prec_valid  input  1  precision code valid
prec_ready  output  1  precision code accepted when both prec_valid and prec_ready are high
prec_code  input  4  0=INT4, 1=INT8, 2=FP16, others=invalid
in_valid  input  1  packed word valid
in_ready  output  1  packed word accepted when both in_valid and in_ready are high
in_data  input  IN_W  packed elements, LSB-first
out_valid  output  1  element valid
out_ready  input  1  downstream accepts element
out_data  output  DATA_WIDTH  decoded element, zero-extended
out_last  output  1  high with the last element (index E-1) of a token
out_token  output  $clog2(L) (min 1)  index of the token being emitted
prec_err  output  1  sticky: an invalid code was seen in this run

Behaviour:
- Reset: all outputs 0, state IDLE, internal word, counters and width registers cleared. Reset mid-run aborts immediately with no completion pulse.
- Width w from code: 0→4, 1→8, 2→16, 3..15→16. An invalid code (3..15) sets prec_err.
- Each token starts on an IN_W word boundary. Bits left in the current word after a token's last element are discarded.
- States and transitions:
  - IDLE: on start, go to PREC; clear token counter and prec_err.
  - PREC: prec_ready=1. On handshake, latch w, set element counter to 0, go to FETCH.
  - FETCH: in_ready=1. On handshake, latch in_data into the word register, set bits_left=IN_W, go to EMIT.
  - EMIT: out_valid=1; out_data = word[w-1:0] zero-extended; out_last = (elem==E-1); out_token = token index. On an out handshake:
    - If elem==E-1 and token==L-1: go to DONE.
    - Else if elem==E-1: increment token, go to PREC.
    - Else: increment elem, shift word right by w, bits_left -= w. If bits_left reaches 0, go to FETCH; otherwise stay in EMIT.
  - DONE: done=1 for exactly one cycle, then IDLE.
- prec_ready, in_ready and out_valid are decoded from the registered state; they are never asserted in the same cycle as each other.
- Latency:
  - out_valid rises the cycle after an input-word handshake.
  - Consecutive elements from one word can issue on back-to-back cycles.
  - A word refetch costs at least one bubble cycle.
  - done rises the cycle after the final out handshake.
- While out_valid=1 and out_ready=0, out_data, out_last and out_token hold stable.
- start outside IDLE is ignored.
- prec_err stays set until the next accepted start.

Test Plan:
1. L=2, E=8, IN_W=32. Token0: code 0, word 0x87654321. Token1: code 1, words 0x44332211 then 0x88776655, out_ready=1 → out_data 0x0001..0x0008 then 0x0011..0x0088. out_last high on the 8th and 16th element. out_token is 0 for the first 8 elements and 1 for the last 8. done is one pulse, the cycle after the final element.
2. Single token, code 2, words 0xBBBBAAAA, 0xDDDDCCCC, 0xFFFFEEEE, 0x22221111 → 8 elements: 0xAAAA, 0xBBBB, …, 0x2222. Exactly 4 input handshakes; in_ready=0 throughout EMIT.
3. Case 1 rerun with out_ready pseudo-random at 50% → same 16 values in order. out_data is stable across every stalled cycle; no element is duplicated or dropped.
4. Token with code 0x5 and words 0x00020001 … → elements are decoded as 16-bit (0x0001, 0x0002, …) and prec_err=1. prec_err stays 1 after done and clears on the next start.
5. Assert rst_n=0 in EMIT after 3 elements → next cycle all outputs are 0. A new run after reset decodes correctly from token 0.
6. Pulse start during EMIT → no state change and the run completes normally. Holding in_valid/prec_valid high while in IDLE → no handshakes occur.

Source files
------------

// File: rtl/mixed_precision_unpacker.sv
// Streaming decoder that expands per-token INT4/INT8/FP16 packed V words into
// one zero-extended element per handshake for the attention MULV datapath.
module mixed_precision_unpacker #(
    parameter  int DATA_WIDTH = 16,
    parameter  int L          = 8,
    parameter  int E          = 8,
    parameter  int IN_W       = 32,
    localparam int TOK_W      = (L > 1) ? $clog2(L) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  done,
    input  logic                  prec_valid,
    output logic                  prec_ready,
    input  logic [3:0]            prec_code,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [TOK_W-1:0]      out_token,
    output logic                  prec_err
);

    localparam int EL_W = (E > 1) ? $clog2(E) : 1;
    localparam int BL_W = $clog2(IN_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREC,
        S_FETCH,
        S_EMIT,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [IN_W-1:0]   word_q;
    logic [BL_W-1:0]   bits_left_q;
    logic [BL_W-1:0]   w_q;
    logic [EL_W-1:0]   elem_q;
    logic [TOK_W-1:0]  token_q;
    logic              prec_err_q;

    logic elem_end;
    logic token_end;

    assign elem_end  = (elem_q == EL_W'(E - 1));
    assign token_end = (token_q == TOK_W'(L - 1));

    // NOTE: every register is sequential state and uses <=; the async reset
    // clears all of them, including the word register, so outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            bits_left_q <= '0;
            w_q         <= '0;
            elem_q      <= '0;
            token_q     <= '0;
            prec_err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        token_q    <= '0;
                        prec_err_q <= 1'b0;
                        state_q    <= S_PREC;
                    end
                end
                S_PREC: begin
                    if (prec_valid) begin
                        case (prec_code)
                            4'd0:    w_q <= BL_W'(4);
                            4'd1:    w_q <= BL_W'(8);
                            default: w_q <= BL_W'(16);
                        endcase
                        prec_err_q <= prec_err_q | (prec_code > 4'd2);
                        elem_q     <= '0;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (in_valid) begin
                        word_q      <= in_data;
                        bits_left_q <= BL_W'(IN_W);
                        state_q     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (elem_end && token_end) begin
                            state_q <= S_DONE;
                        end else if (elem_end) begin
                            // Leftover bits in the word are dropped; next token is word-aligned.
                            token_q <= token_q + 1'b1;
                            state_q <= S_PREC;
                        end else begin
                            elem_q      <= elem_q + 1'b1;
                            word_q      <= word_q >> w_q;
                            bits_left_q <= bits_left_q - w_q;
                            if (bits_left_q == w_q) begin
                                state_q <= S_FETCH;
                            end
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign prec_ready = (state_q == S_PREC);
    assign in_ready   = (state_q == S_FETCH);
    assign out_valid  = (state_q == S_EMIT);
    assign done       = (state_q == S_DONE);
    assign out_last   = (state_q == S_EMIT) && elem_end;
    assign out_token  = token_q;
    assign prec_err   = prec_err_q;

    always_comb begin
        case (w_q)
            BL_W'(4):  out_data = DATA_WIDTH'(word_q[3:0]);
            BL_W'(8):  out_data = DATA_WIDTH'(word_q[7:0]);
            default:   out_data = word_q[DATA_WIDTH-1:0];
        endcase
    end

endmodule

// File: tb/tb_mixed_precision_unpacker.sv
// Directed bench for mixed_precision_unpacker: a bit-offset model of the token
// layout predicts every element, and a per-cycle compare checks the DUT.
module tb_mixed_precision_unpacker;

    localparam int DW    = 16;
    localparam int L     = 2;
    localparam int E     = 8;
    localparam int IN_W  = 32;
    localparam int TOK_W = 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             done;
    logic             prec_valid;
    logic             prec_ready;
    logic [3:0]       prec_code;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic             out_last;
    logic [TOK_W-1:0] out_token;
    logic             prec_err;

    mixed_precision_unpacker #(
        .DATA_WIDTH(DW), .L(L), .E(E), .IN_W(IN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done),
        .prec_valid(prec_valid), .prec_ready(prec_ready), .prec_code(prec_code),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_token(out_token), .prec_err(prec_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          token;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [3:0]  tok_code[$];
    logic [31:0] tok_word[$];
    logic [15:0] got[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int width_of(input logic [3:0] code);
        if (code == 4'd0) return 4;
        if (code == 4'd1) return 8;
        return 16;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_done"},      done,       0);
        check({tag, "_prec_rdy"},  prec_ready, 0);
        check({tag, "_in_rdy"},    in_ready,   0);
        check({tag, "_out_valid"}, out_valid,  0);
        check({tag, "_out_data"},  out_data,   0);
        check({tag, "_out_last"},  out_last,   0);
        check({tag, "_out_token"}, out_token,  0);
        check({tag, "_prec_err"},  prec_err,   0);
    endtask

    // One full run over tok_code/tok_word. ready_pct sets out_ready density;
    // mid_start pulses start once during EMIT; abort_after>0 resets after that many elements.
    task automatic run(input int ready_pct, input bit mid_start, input int abort_after, input logic exp_err);
        exp_t        exq[$];
        exp_t        x;
        logic [3:0]  pq[$];
        logic [31:0] wq[$];
        int          base, nw, w, cyc, nout, n_in, total;
        bit          done_due, done_seen, hold, in_hs_prev, mid_sent;
        logic [15:0] hd;
        logic        hl;
        logic [TOK_W-1:0] ht;

        got.delete();
        base = 0;
        foreach (tok_code[t]) begin
            w  = width_of(tok_code[t]);
            nw = (E * w + IN_W - 1) / IN_W;
            for (int i = 0; i < E; i++) begin
                int          bit_pos;
                logic [31:0] src;
                bit_pos = i * w;
                src     = tok_word[base + bit_pos / IN_W];
                x.data  = 16'((src >> (bit_pos % IN_W)) & ((32'd1 << w) - 1));
                x.last  = (i == E - 1);
                x.token = t;
                exq.push_back(x);
            end
            base += nw;
            pq.push_back(tok_code[t]);
        end
        wq    = tok_word;
        total = exq.size();

        cyc = 0; nout = 0; n_in = 0;
        done_due = 0; done_seen = 0; hold = 0; in_hs_prev = 0; mid_sent = 0;
        while (1) begin
            @(negedge clk);
            if (cyc > 2000) begin
                check("timeout", 1, 0);
                break;
            end
            if (abort_after > 0 && nout == abort_after && out_valid) begin
                rst_n = 1'b0;
                start = 1'b0; prec_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
                @(negedge clk);
                check_all_zero("abort");
                rst_n = 1'b1;
                return;
            end

            if (cyc == 1) check("err_clear_on_start", prec_err, 0);
            check("exclusive_ready_valid", (int'(prec_ready) + int'(in_ready) + int'(out_valid)) > 1, 0);
            check("done", done, done_due);
            if (in_hs_prev) check("valid_after_fetch", out_valid, 1);
            if (hold) begin
                check("stall_valid", out_valid, 1);
                check("stall_data",  out_data,  hd);
                check("stall_last",  out_last,  hl);
                check("stall_token", out_token, ht);
            end
            if (done_seen) begin
                check("err_final", prec_err, exp_err);
                check("in_count",  n_in, base);
                check("out_count", nout, total);
                break;
            end
            done_seen = done_due;
            done_due  = 0;

            start = (cyc == 0) || (mid_start && out_valid && !mid_sent);
            if (mid_start && out_valid) mid_sent = 1;
            prec_valid = (pq.size() > 0);
            prec_code  = prec_valid ? pq[0] : 4'd0;
            in_valid   = (wq.size() > 0);
            in_data    = in_valid ? wq[0] : 32'd0;
            out_ready  = ($urandom_range(99) < ready_pct);

            hold = 0; in_hs_prev = 0;
            if (prec_valid && prec_ready) void'(pq.pop_front());
            if (in_valid && in_ready) begin
                void'(wq.pop_front());
                n_in++;
                in_hs_prev = 1;
            end
            if (out_valid) begin
                if (out_ready) begin
                    if (exq.size() == 0) begin
                        check("extra_element", 1, 0);
                    end else begin
                        x = exq.pop_front();
                        check("out_data",  out_data,  x.data);
                        check("out_last",  out_last,  x.last);
                        check("out_token", out_token, x.token);
                        got.push_back(out_data);
                        nout++;
                        if (exq.size() == 0) done_due = 1;
                    end
                end else begin
                    hold = 1; hd = out_data; hl = out_last; ht = out_token;
                end
            end
            cyc++;
        end
        start = 1'b0; prec_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic load_case1();
        tok_code = '{4'd0, 4'd1};
        tok_word = '{32'h87654321, 32'h44332211, 32'h88776655};
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; prec_valid = 1'b0; prec_code = 4'd0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // INT4 token then INT8 token.
        load_case1();
        run(100, 0, 0, 1'b0);
        check("c1_first",  got[0],  16'h0001);
        check("c1_eighth", got[7],  16'h0008);
        check("c1_ninth",  got[8],  16'h0011);
        check("c1_last",   got[15], 16'h0088);

        // FP16 tokens: four words each.
        tok_code = '{4'd2, 4'd2};
        tok_word = '{32'hBBBBAAAA, 32'hDDDDCCCC, 32'hFFFFEEEE, 32'h22221111,
                     32'h43214321, 32'h87658765, 32'hCBA9CBA9, 32'h0FED0FED};
        run(100, 0, 0, 1'b0);
        check("c2_first",  got[0], 16'hAAAA);
        check("c2_second", got[1], 16'hBBBB);
        check("c2_eighth", got[7], 16'h2222);

        // Random backpressure.
        load_case1();
        run(50, 0, 0, 1'b0);

        // Invalid code decodes as 16-bit and flags prec_err.
        tok_code = '{4'd5, 4'd0};
        tok_word = '{32'h00020001, 32'h00040003, 32'h00060005, 32'h00080007, 32'h12345678};
        run(100, 0, 0, 1'b1);
        check("c4_first",  got[0], 16'h0001);
        check("c4_second", got[1], 16'h0002);
        check("c4_tok1",   got[8], 16'h0008);
        repeat (2) @(negedge clk);
        check("c4_err_sticky", prec_err, 1);

        // Abort mid-EMIT, then a clean run from token 0.
        load_case1();
        run(100, 0, 3, 1'b0);
        run(100, 0, 0, 1'b0);
        check("c5_rerun_first", got[0], 16'h0001);

        // Valid inputs held in IDLE must not handshake.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            prec_valid = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF;
            @(negedge clk);
            check("idle_prec_ready", prec_ready, 0);
            check("idle_in_ready",   in_ready,   0);
            check("idle_out_valid",  out_valid,  0);
        end
        prec_valid = 1'b0; in_valid = 1'b0;

        // start pulsed during EMIT is ignored.
        run(100, 1, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("c6_idle_after", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
